// File: rtl/riscv_ex_branch_unit.sv
// rtl/riscv_ex_branch_unit.sv - EX-stage ALU, decode branch detector, prediction checker and branch statistics
module riscv_ex_branch_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      Inst_DE,
    output logic             Br_Detected,
    input  logic [XLEN-1:0]  ALU_A,
    input  logic [XLEN-1:0]  ALU_B,
    input  logic [3:0]       ALUSel,
    output logic [XLEN-1:0]  ALU_Out,
    input  logic             Br_Valid,
    input  logic             Predicted,
    input  logic             Execute,
    input  logic [XLEN-1:0]  PC_Pre,
    output logic [1:0]       Result,
    output logic [1:0]       Last_Result,
    output logic [CNT_W-1:0] Br_Count,
    output logic [CNT_W-1:0] Mispredict_Count
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] RES_OK_NT    = 2'b00;
    localparam logic [1:0] RES_OK_T     = 2'b01;
    localparam logic [1:0] RES_REDIR_T  = 2'b10;
    localparam logic [1:0] RES_REDIR_NT = 2'b11;

    logic [4:0]      shamt;
    logic            slt_bit;
    logic            sltu_bit;
    logic            mispredict;
    logic [24:0]     unused_inst_bits;

    assign shamt            = ALU_B[4:0];
    assign slt_bit          = $signed(ALU_A) < $signed(ALU_B);
    assign sltu_bit         = ALU_A < ALU_B;
    assign unused_inst_bits = Inst_DE[31:7];

    always_comb begin
        ALU_Out = '0;
        case (ALUSel)
            ALU_ADD:  ALU_Out = ALU_A + ALU_B;
            ALU_SUB:  ALU_Out = ALU_A - ALU_B;
            ALU_SLL:  ALU_Out = ALU_A << shamt;
            ALU_SLT:  ALU_Out = {{(XLEN-1){1'b0}}, slt_bit};
            ALU_SLTU: ALU_Out = {{(XLEN-1){1'b0}}, sltu_bit};
            ALU_XOR:  ALU_Out = ALU_A ^ ALU_B;
            ALU_SRL:  ALU_Out = ALU_A >> shamt;
            ALU_SRA:  ALU_Out = $unsigned($signed(ALU_A) >>> shamt);
            ALU_OR:   ALU_Out = ALU_A | ALU_B;
            ALU_AND:  ALU_Out = ALU_A & ALU_B;
            ALU_LUI:  ALU_Out = ALU_B;
            default:  ALU_Out = '0;
        endcase
    end

    assign Br_Detected = (Inst_DE[6:0] == OP_BRANCH) ||
                         (Inst_DE[6:0] == OP_JAL)    ||
                         (Inst_DE[6:0] == OP_JALR);

    // A taken branch is only "correct" if the carried target matches the computed one.
    always_comb begin
        Result = RES_OK_NT;
        if (Br_Valid) begin
            if (Execute) begin
                if (Predicted && (PC_Pre == ALU_Out)) begin
                    Result = RES_OK_T;
                end else begin
                    Result = RES_REDIR_T;
                end
            end else if (Predicted) begin
                Result = RES_REDIR_NT;
            end
        end
    end

    assign mispredict = Result[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Last_Result      <= 2'b00;
            Br_Count         <= '0;
            Mispredict_Count <= '0;
        end else if (Br_Valid) begin
            Last_Result <= Result;
            if (Br_Count != {CNT_W{1'b1}}) begin
                Br_Count <= Br_Count + CNT_W'(1);
            end
            if (mispredict && (Mispredict_Count != {CNT_W{1'b1}})) begin
                Mispredict_Count <= Mispredict_Count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_riscv_ex_branch_unit.sv
// tb/tb_riscv_ex_branch_unit.sv - scoreboard bench for riscv_ex_branch_unit
module tb_riscv_ex_branch_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    localparam int K_ALU  = 0;
    localparam int K_DET  = 1;
    localparam int K_RES  = 2;
    localparam int K_LAST = 3;
    localparam int K_BRC  = 4;
    localparam int K_MISC = 5;

    logic             clk;
    logic             rst_n;
    logic [31:0]      Inst_DE;
    logic             Br_Detected;
    logic [XLEN-1:0]  ALU_A;
    logic [XLEN-1:0]  ALU_B;
    logic [3:0]       ALUSel;
    logic [XLEN-1:0]  ALU_Out;
    logic             Br_Valid;
    logic             Predicted;
    logic             Execute;
    logic [XLEN-1:0]  PC_Pre;
    logic [1:0]       Result;
    logic [1:0]       Last_Result;
    logic [CNT_W-1:0] Br_Count;
    logic [CNT_W-1:0] Mispredict_Count;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    riscv_ex_branch_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .Inst_DE          (Inst_DE),
        .Br_Detected      (Br_Detected),
        .ALU_A            (ALU_A),
        .ALU_B            (ALU_B),
        .ALUSel           (ALUSel),
        .ALU_Out          (ALU_Out),
        .Br_Valid         (Br_Valid),
        .Predicted        (Predicted),
        .Execute          (Execute),
        .PC_Pre           (PC_Pre),
        .Result           (Result),
        .Last_Result      (Last_Result),
        .Br_Count         (Br_Count),
        .Mispredict_Count (Mispredict_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_ALU:   return ALU_Out;
            K_DET:   return {31'd0, Br_Detected};
            K_RES:   return {30'd0, Result};
            K_LAST:  return {30'd0, Last_Result};
            K_BRC:   return {16'd0, Br_Count};
            default: return {16'd0, Mispredict_Count};
        endcase
    endfunction

    // Monitor: compares everything queued for the current cycle at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = actual(e.kind);
            checks = checks + 1;
            if (act !== e.exp) begin
                errors = errors + 1;
                $display("FAIL %s actual=0x%08h required=0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string name, input int kind, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_vec(input string name, input logic [3:0] sel, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        step();
        ALUSel = sel;
        ALU_A  = a;
        ALU_B  = b;
        expect_val(name, K_ALU, exp);
    endtask

    task automatic det_vec(input string name, input logic [31:0] inst, input logic exp);
        step();
        Inst_DE = inst;
        expect_val(name, K_DET, {31'd0, exp});
    endtask

    task automatic br_vec(input string name, input logic v, input logic p, input logic x,
                          input logic [31:0] pc_pre, input logic [31:0] target,
                          input logic [1:0] exp);
        step();
        Br_Valid  = v;
        Predicted = p;
        Execute   = x;
        PC_Pre    = pc_pre;
        ALUSel    = 4'd0;
        ALU_A     = target;
        ALU_B     = 32'd0;
        expect_val(name, K_RES, {30'd0, exp});
    endtask

    task automatic expect_regs(input string tag, input logic [1:0] last,
                               input logic [15:0] brc, input logic [15:0] misc);
        expect_val({tag, "_last"}, K_LAST, {30'd0, last});
        expect_val({tag, "_brcnt"}, K_BRC, {16'd0, brc});
        expect_val({tag, "_miscnt"}, K_MISC, {16'd0, misc});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; Inst_DE = 32'd0; ALU_A = '0; ALU_B = '0; ALUSel = 4'd0;
        Br_Valid = 1'b0; Predicted = 1'b0; Execute = 1'b0; PC_Pre = '0;
        repeat (3) step();
        rst_n = 1'b1;
        expect_regs("reset", 2'b00, 16'd0, 16'd0);

        alu_vec("alu_add_ovf", 4'd0,  32'h7FFFFFFF, 32'd1,        32'h80000000);
        alu_vec("alu_sub",     4'd1,  32'd0,        32'd1,        32'hFFFFFFFF);
        alu_vec("alu_slt",     4'd3,  32'hFFFFFFFF, 32'd1,        32'd1);
        alu_vec("alu_sltu",    4'd4,  32'hFFFFFFFF, 32'd1,        32'd0);
        alu_vec("alu_sra",     4'd7,  32'h80000000, 32'd4,        32'hF8000000);
        alu_vec("alu_srl",     4'd6,  32'h80000000, 32'd4,        32'h08000000);
        alu_vec("alu_sll",     4'd2,  32'h00000003, 32'h00000024, 32'h00000030);
        alu_vec("alu_xor",     4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
        alu_vec("alu_or",      4'd8,  32'hF0F0F0F0, 32'h0000FFFF, 32'hF0F0FFFF);
        alu_vec("alu_and",     4'd9,  32'hF0F0F0F0, 32'h0000FFFF, 32'h0000F0F0);
        alu_vec("alu_lui",     4'd10, 32'hDEADBEEF, 32'h12345000, 32'h12345000);
        alu_vec("alu_sel13",   4'd13, 32'hDEADBEEF, 32'h12345000, 32'd0);

        det_vec("det_beq",  32'h00208463, 1'b1);
        det_vec("det_jal",  32'h008000EF, 1'b1);
        det_vec("det_jalr", 32'h000080E7, 1'b1);
        det_vec("det_add",  32'h00208033, 1'b0);
        det_vec("det_zero", 32'h00000000, 1'b0);

        expect_regs("pre_stats", 2'b00, 16'd0, 16'd0);
        br_vec("res_ok_taken",   1'b1, 1'b1, 1'b1, 32'h100, 32'h100, 2'b01);
        br_vec("res_bad_target", 1'b1, 1'b1, 1'b1, 32'h100, 32'h104, 2'b10);
        br_vec("res_not_pred",   1'b1, 1'b0, 1'b1, 32'h100, 32'h100, 2'b10);
        br_vec("res_pred_nt",    1'b1, 1'b1, 1'b0, 32'h100, 32'h100, 2'b11);
        br_vec("res_ok_nt",      1'b1, 1'b0, 1'b0, 32'h100, 32'h100, 2'b00);
        br_vec("res_invalid",    1'b0, 1'b1, 1'b0, 32'h100, 32'h100, 2'b00);
        expect_regs("stats", 2'b00, 16'd5, 16'd3);

        step();
        br_vec("res_idle_pred", 1'b0, 1'b1, 1'b1, 32'h100, 32'h104, 2'b00);
        step();
        step();
        expect_regs("hold", 2'b00, 16'd5, 16'd3);

        step();
        rst_n = 1'b0;
        expect_regs("async_rst", 2'b00, 16'd0, 16'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        step();
        Br_Valid = 1'b1; Predicted = 1'b1; Execute = 1'b0;
        expect_val("sat_first_res", K_RES, 32'd3);
        for (int i = 0; i < 65540; i++) begin
            step();
        end
        Br_Valid = 1'b0;
        expect_regs("saturate", 2'b11, 16'hFFFF, 16'hFFFF);

        step();
        step();
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
